// File: rtl/counter_ctrl.sv
// Run/pause/step/clear sequencer for the board up-counter: debounces the three
// pushbuttons, divides CLOCK_50 into a rate-selectable tick, and drives cnt_en/cnt_clr.

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic          deb_level, deb_level_d;
    logic [CW-1:0] deb_cnt;
    logic          s;

    assign s = ~sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            deb_level   <= 1'b0;
            deb_level_d <= 1'b0;
            deb_cnt     <= '0;
            press       <= 1'b0;
        end else begin
            sync1       <= key_n;
            sync2       <= sync1;
            deb_level_d <= deb_level;
            press       <= deb_level & ~deb_level_d;
            if (s == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == LAST) begin
                deb_level <= s;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end
endmodule

module counter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_run_n,
    input  logic       key_step_n,
    input  logic       key_clr_n,
    input  logic [1:0] rate,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       running
);
    localparam int NUM_KEYS = 3;
    localparam int PW       = $clog2(TICK_DIV);
    localparam logic [31:0] TICK_DIV_W = 32'(TICK_DIV);

    typedef enum logic { STOPPED = 1'b0, RUNNING = 1'b1 } state_t;

    state_t              state;
    logic [PW-1:0]       presc;
    logic [NUM_KEYS-1:0] keys_n, press;
    logic [31:0]         div_m1;
    logic                tick_due;
    logic                run_ev, step_ev, clr_ev;

    // Key lanes: 0 = run, 1 = step, 2 = clear.
    assign keys_n = {key_clr_n, key_step_n, key_run_n};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk   (CLOCK_50),
            .reset (reset),
            .key_n (keys_n[i]),
            .press (press[i])
        );
    end

    assign run_ev  = press[0];
    assign step_ev = press[1];
    assign clr_ev  = press[2];

    // >= rather than == so a rate switch to a shorter period ticks promptly.
    assign div_m1   = (TICK_DIV_W >> rate) - 32'd1;
    assign tick_due = 32'(presc) >= div_m1;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= STOPPED;
            presc   <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            running <= 1'b0;
        end else begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            if (clr_ev || run_ev) begin
                presc   <= '0;
                cnt_clr <= clr_ev;
                if (run_ev) begin
                    state   <= (state == STOPPED) ? RUNNING : STOPPED;
                    running <= (state == STOPPED);
                end
            end else if (state == RUNNING) begin
                if (tick_due) begin
                    cnt_en <= 1'b1;
                    presc  <= '0;
                end else begin
                    presc <= presc + PW'(1);
                end
            end else begin
                presc  <= '0;
                cnt_en <= step_ev;
            end
        end
    end
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed and random checks of counter_ctrl against an edge-indexed history model
// (debounce judged from a sliding window of synchronized key samples).

module tb_counter_ctrl;
    localparam int D    = 4;
    localparam int TD   = 16;
    localparam int MAXE = 4096;

    logic       CLOCK_50   = 1'b0;
    logic       reset      = 1'b1;
    logic       key_run_n  = 1'b1;
    logic       key_step_n = 1'b1;
    logic       key_clr_n  = 1'b1;
    logic [1:0] rate       = 2'd0;
    logic       cnt_en, cnt_clr, running;

    counter_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .key_run_n  (key_run_n),
        .key_step_n (key_step_n),
        .key_clr_n  (key_clr_n),
        .rate       (rate),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .running    (running)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0, bad = 0, n = 0;
    int en_seen = 0, clr_seen = 0;

    // Input history per edge; key order 0 = run, 1 = step, 2 = clear.
    bit rst_a [MAXE];
    bit rawp  [3][MAXE];
    bit lvl   [3][MAXE];
    int rate_a[MAXE];
    bit m_run = 1'b0;
    int m_age = 0;
    bit exp_en = 1'b0, exp_clr = 1'b0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, n, obs, expv);
        end
    endtask

    // Synchronized pressed level during cycle c (the cycle after edge c).
    function automatic bit s_at(int k, int c);
        if (c < 1) return 1'b0;
        if (rst_a[c] || rst_a[c-1]) return 1'b0;
        return rawp[k][c-1];
    endfunction

    task automatic model(int t);
        bit pr[3];
        for (int k = 0; k < 3; k++) begin
            if (rst_a[t] || t == 0) begin
                lvl[k][t] = 1'b0;
            end else begin
                bit prev, flip;
                prev = lvl[k][t-1];
                flip = (t >= D);
                for (int c = t - D; c < t; c++)
                    if (c >= 0 && s_at(k, c) == prev) flip = 1'b0;
                lvl[k][t] = flip ? !prev : prev;
            end
            pr[k] = (t >= 3) && !rst_a[t-1] && lvl[k][t-2] && !lvl[k][t-3];
        end
        exp_en  = 1'b0;
        exp_clr = 1'b0;
        if (rst_a[t]) begin
            m_run = 1'b0;
            m_age = 0;
        end else if (pr[2] || pr[0]) begin
            exp_clr = pr[2];
            if (pr[0]) m_run = !m_run;
            m_age = 0;
        end else if (!m_run) begin
            exp_en = pr[1];
            m_age  = 0;
        end else if (m_age >= (TD >> rate_a[t]) - 1) begin
            exp_en = 1'b1;
            m_age  = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic tick();
        if (n >= MAXE) begin
            $display("FAIL edge_budget n=%0d limit=%0d", n, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        rst_a[n]   = reset;
        rawp[0][n] = !key_run_n;
        rawp[1][n] = !key_step_n;
        rawp[2][n] = !key_clr_n;
        rate_a[n]  = int'(rate);
        @(posedge CLOCK_50);
        model(n);
        @(negedge CLOCK_50);
        check("cnt_en", cnt_en, exp_en);
        check("cnt_clr", cnt_clr, exp_clr);
        check("running", running, m_run);
        check("en_clr_excl", cnt_en & cnt_clr, 0);
        if (cnt_en === 1'b1) en_seen++;
        if (cnt_clr === 1'b1) clr_seen++;
        n++;
    endtask

    initial begin
        int g;
        // Reset, then idle.
        reset = 1'b1;
        repeat (3) tick();
        check("rst_running", running, 0);
        reset = 1'b0;
        en_seen = 0; clr_seen = 0;
        g = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (running !== 1'b0) g++;
        end
        check("idle_en", en_seen, 0);
        check("idle_clr", clr_seen, 0);
        check("idle_running", g, 0);

        // Run timing at rate 0.
        key_run_n = 1'b0;
        en_seen = 0;
        for (int i = 0; i <= 60; i++) begin
            if (i == 10) key_run_n = 1'b1;
            tick();
            if (i == 6) check("run_early", running, 0);
            if (i == 7) check("run_rise", running, 1);
            if (i == 22 || i == 24) check("run_tick_gap", cnt_en, 0);
            if (i == 23 || i == 39 || i == 55) check("run_tick", cnt_en, 1);
        end
        check("run_tick_count", en_seen, 3);

        // Rate 2: already past div-1, so tick next edge, then every 4.
        rate = 2'd2;
        en_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0 || i == 4 || i == 8) check("rate2_tick", cnt_en, 1);
        end
        check("rate2_count", en_seen, 5);

        // Rate shrink from 16 to 2 with the prescaler at 10.
        rate = 2'd0;
        g = 0;
        while (m_age != 10 && g < 40) begin tick(); g++; end
        check("shrink_reach", g < 40, 1);
        rate = 2'd3;
        tick(); check("shrink_next", cnt_en, 1);
        tick(); check("shrink_gap", cnt_en, 0);
        tick(); check("shrink_period", cnt_en, 1);
        tick(); check("shrink_gap2", cnt_en, 0);
        tick(); check("shrink_period2", cnt_en, 1);

        // Stop.
        key_run_n = 1'b0;
        repeat (6) tick();
        key_run_n = 1'b1;
        repeat (10) tick();
        check("stopped", running, 0);

        // Bounce rejection, then a clean step.
        en_seen = 0;
        for (int r = 0; r < 5; r++) begin
            key_step_n = 1'b0;
            repeat (3) tick();
            key_step_n = 1'b1;
            tick();
        end
        repeat (8) tick();
        check("bounce_none", en_seen, 0);
        key_step_n = 1'b0;
        repeat (6) tick();
        key_step_n = 1'b1;
        repeat (12) tick();
        check("step_once", en_seen, 1);

        // Clear and step together while stopped.
        en_seen = 0; clr_seen = 0;
        key_clr_n = 1'b0; key_step_n = 1'b0;
        repeat (6) tick();
        key_clr_n = 1'b1; key_step_n = 1'b1;
        repeat (12) tick();
        check("simul_clr", clr_seen, 1);
        check("simul_no_en", en_seen, 0);
        check("simul_stopped", running, 0);

        // Reset mid-run with run key held through it.
        key_run_n = 1'b0;
        repeat (6) tick();
        key_run_n = 1'b1;
        repeat (6) tick();
        check("run_again", running, 1);
        key_run_n = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("reset_stop", running, 0);
        reset = 1'b0;
        en_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) check("held_early", running, 0);
            if (i == 7) check("held_rise", running, 1);
        end
        check("post_reset_no_en", en_seen, 0);
        key_run_n = 1'b1;
        repeat (10) tick();

        // Random key activity, rate changes and occasional resets.
        for (int seg = 0; seg < 150 && n < MAXE - 40; seg++) begin
            int which, lo, hi;
            which = $urandom_range(0, 2);
            lo    = $urandom_range(1, 8);
            hi    = $urandom_range(1, 10);
            if ($urandom_range(0, 9) == 0) rate = 2'($urandom_range(0, 3));
            if (which == 0) key_run_n = 1'b0;
            if (which == 1) key_step_n = 1'b0;
            if (which == 2) key_clr_n = 1'b0;
            if ($urandom_range(0, 5) == 0) key_step_n = 1'b0;
            repeat (lo) tick();
            key_run_n = 1'b1; key_step_n = 1'b1; key_clr_n = 1'b1;
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            repeat (hi) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run/pause/step/clear sequencer for the board-level up-counter datapath. Sits between the DE-series pushbuttons and switches on one side and the counter's enable and clear inputs on the other.
- Synchronizes and debounces the active-low KEY inputs.
- Generates a rate-selectable count-enable tick from CLOCK_50.
- Sequences the counter through stopped and running modes, with single-step and clear.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles (10 ms at 50 MHz) needed before a key level is accepted.
- TICK_DIV, default 5000000: base divisor for the run-mode tick (10 Hz at 50 MHz). Must be ≥ 8.

Ports:
- CLOCK_50, input, 1: DE-series 50 MHz clock. This block uses one clock only.
- reset, input, 1: synchronous, active-high reset.
- key_run_n, input, 1: pushbutton, active-low. A press toggles between running and stopped.
- key_step_n, input, 1: pushbutton, active-low. A press gives a single count while stopped.
- key_clr_n, input, 1: pushbutton, active-low. A press clears the counter.
- rate, input, 2: switch-selected tick rate. The divisor is TICK_DIV >> rate.
- cnt_en, output, 1: one-cycle count-enable pulse to the counter.
- cnt_clr, output, 1: one-cycle synchronous clear pulse to the counter.
- running, output, 1: high in RUNNING state. Drives the status LED.

## Operation
Key input path, identical for each of the three keys:
- 2-FF synchronizer, then inversion, gives the synchronized level s (1 = pressed).
- Debounce counter:
  - If s ≠ deb_level, the counter increments.
  - When s has differed for DEBOUNCE_CYCLES consecutive cycles, deb_level ← s and the counter ← 0.
  - Any cycle with s = deb_level resets the counter to 0.
- Press event: deb_level rising edge, one cycle wide. Release generates no event.

State machine, two states:
- STOPPED is the reset state.
- STOPPED → RUNNING on a run press. RUNNING → STOPPED on a run press.

Prescaler:
- Width $clog2(TICK_DIV). Active only in RUNNING.
- Increments every cycle.
- When prescaler ≥ div−1, where div = TICK_DIV >> rate:
  - cnt_en pulses.
  - prescaler wraps to 0.
- The ≥ comparison handles a rate switch to a smaller divisor mid-period: tick on the next cycle, then the normal period.
- rate is sampled every cycle. It needs no synchronizer: it is a static switch, and the ≥ compare is glitch-tolerant.
- On any state change, prescaler ← 0.

Step press:
- In STOPPED: cnt_en pulses once.
- In RUNNING: ignored.

Clear press:
- cnt_clr pulses once and prescaler ← 0.
- State is unchanged.
- Any cnt_en that would occur in the same cycle is suppressed.

Simultaneous events in one cycle, in priority order: clear, then run toggle, then step.
- Clear + run press: cnt_clr pulses, state toggles, prescaler ← 0.
- Run + step press while STOPPED: the state goes to RUNNING. No step pulse.

Reset values:
- cnt_en = 0, cnt_clr = 0, running = 0.
- State STOPPED, prescaler = 0.
- All debounce counters = 0, deb_levels = 0, synchronizer flops = 1 (released).

Reset mid-operation:
- Returns to STOPPED on the next edge.
- A key held through reset must be re-debounced. It produces a press event only after DEBOUNCE_CYCLES, as a new press.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Key press to output response: a key sampled low at edge 0 and held produces:
  - the internal press event in cycle DEBOUNCE_CYCLES+2;
  - the output (cnt_clr, cnt_en step, or running change) in cycle DEBOUNCE_CYCLES+3.
- Bounce: a key low for only DEBOUNCE_CYCLES−1 cycles produces no event.
- Run mode: the first cnt_en is div cycles after running rises. Thereafter cnt_en is high exactly 1 cycle in every div.
- cnt_en and cnt_clr are never high in the same cycle.
- A held key produces exactly one event per press.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TICK_DIV=16.
- Reset: apply reset for 3 cycles, then keys high and rate=0 → running=0, cnt_en=0, cnt_clr=0 for 100 cycles.
- Run timing: hold key_run_n low 10 cycles → running=1 at cycle 7. cnt_en pulses at cycles 23, 39, 55 (period 16). With rate=2, the period is 4.
- Bounce rejection: toggle key_step_n low 3 cycles / high 1 cycle, repeated 5 times while STOPPED → no cnt_en. Then hold it low 6 cycles → exactly one cnt_en.
- Rate shrink mid-period: in RUNNING at prescaler=10, switch rate 0→3 (div=2) → cnt_en on the next cycle, then every 2 cycles.
- Simultaneous keys: in STOPPED, press key_clr_n and key_step_n on the same cycle → cnt_clr=1 for one cycle, no cnt_en, running=0.
- Reset mid-run: in RUNNING, assert reset for one cycle → running=0 next cycle, no cnt_en afterwards. A key_run_n held through reset produces running=1 only after 4+3 cycles post-reset.
